// File: rtl/brq_pkg.sv
// ----------------------------------------------------------------------------
// brq_pkg
// Shared types and constants for the FPU controller slice:
//   - fpu_ctrl_state_e : controller FSM states
//   - RM_*             : RISC-V rounding-mode encodings (RNE..RMM, DYN)
//   - FFLAG_*          : bit positions inside the 5-bit fflags vector
//   - rm_is_legal()    : legality of an already-resolved rounding mode
// ----------------------------------------------------------------------------
package brq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } fpu_ctrl_state_e;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;
  localparam logic [2:0] RM_DYN = 3'd7;

  // fflags layout {NV,DZ,OF,UF,NX}
  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_NV = 4;

  // After DYN substitution only RNE..RMM are usable; 5, 6 and 7 are reserved.
  function automatic logic rm_is_legal(input logic [2:0] rm);
    return (rm <= RM_RMM);
  endfunction

endpackage

// File: rtl/brq_fpu_rm_resolve.sv
// ----------------------------------------------------------------------------
// brq_fpu_rm_resolve
// Combinational rounding-mode resolution. A DYN instruction rm takes the
// frm CSR value; the resolved value is then checked for legality.
// Ports:
//   dec_rm_i  [2:0] : instruction rm field
//   frm_csr_i [2:0] : CSR frm value
//   rm_o      [2:0] : resolved rounding mode
//   legal_o         : 1 when rm_o is RNE..RMM
// ----------------------------------------------------------------------------
module brq_fpu_rm_resolve
  import brq_pkg::*;
(
  input  logic [2:0] dec_rm_i,
  input  logic [2:0] frm_csr_i,
  output logic [2:0] rm_o,
  output logic       legal_o
);

  logic [2:0] w_rm;

  assign w_rm    = (dec_rm_i == RM_DYN) ? frm_csr_i : dec_rm_i;
  assign rm_o    = w_rm;
  assign legal_o = rm_is_legal(w_rm);

endmodule

// File: rtl/brq_fpu_ctrl.sv
// ----------------------------------------------------------------------------
// brq_fpu_ctrl
// Sequences one FP instruction at a time through an external FPU:
// accept from decoder, issue to FPU, wait for the result, write back
// result and fflags, with rounding-mode checking, a timeout and flush.
//
// Handshakes: every valid/ready pair transfers on a rising clk edge where
// both are high. A valid, once raised, stays high with stable payload until
// the transfer; ready may be raised or dropped freely.
//
// Ports:
//   clk_i, rst_ni                 : clock, async active-low reset
//   dec_valid_i/dec_ready_o       : instruction handshake from decoder
//   dec_rm_i, dec_rd_i, dec_fp_wb_i : instruction rm, rd, FP/int regfile select
//   frm_csr_i                     : CSR frm for DYN rounding
//   fpu_in_valid_o/fpu_in_ready_i : FPU issue handshake, fpu_rm_o = rm
//   fpu_out_valid_i/fpu_out_ready_o, fpu_result_i, fpu_status_i : FPU result
//   fpu_flush_o, flush_i          : flush out to FPU / pipeline flush in
//   wb_valid_o, wb_fp_o, wb_rd_o, wb_data_o : writeback
//   fflags_we_o, fflags_o         : fflags accrual
//   illegal_rm_o, timeout_o       : one-cycle error pulses
//   busy_o                        : operation in flight
//   dbg_state_o                   : current FSM state (fpu_ctrl_state_e)
// ----------------------------------------------------------------------------
module brq_fpu_ctrl
  import brq_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             dec_valid_i,
  output logic             dec_ready_o,
  input  logic [2:0]       dec_rm_i,
  input  logic [4:0]       dec_rd_i,
  input  logic             dec_fp_wb_i,
  input  logic [2:0]       frm_csr_i,
  output logic             fpu_in_valid_o,
  input  logic             fpu_in_ready_i,
  output logic [2:0]       fpu_rm_o,
  input  logic             fpu_out_valid_i,
  output logic             fpu_out_ready_o,
  input  logic [WIDTH-1:0] fpu_result_i,
  input  logic [4:0]       fpu_status_i,
  output logic             fpu_flush_o,
  input  logic             flush_i,
  output logic             wb_valid_o,
  output logic             wb_fp_o,
  output logic [4:0]       wb_rd_o,
  output logic [WIDTH-1:0] wb_data_o,
  output logic             fflags_we_o,
  output logic [4:0]       fflags_o,
  output logic             illegal_rm_o,
  output logic             timeout_o,
  output logic             busy_o,
  output logic [1:0]       dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fpu_ctrl_state_e  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_rd;
  logic             r_fp_wb;
  logic [2:0]       r_rm;
  logic [WIDTH-1:0] r_data;
  logic [4:0]       r_status;
  logic             r_illegal;
  logic             r_timeout;

  logic [2:0] w_rm;
  logic       w_rm_legal;
  logic       w_accept;
  logic       w_capture;
  logic       w_in_flight;

  brq_fpu_rm_resolve u_rm_resolve (
    .dec_rm_i  (dec_rm_i),
    .frm_csr_i (frm_csr_i),
    .rm_o      (w_rm),
    .legal_o   (w_rm_legal)
  );

  assign w_in_flight = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

  // rst_ni gates the ready so the decoder sees no acceptance during reset.
  assign dec_ready_o     = rst_ni && (r_state == ST_IDLE) && !flush_i;
  assign fpu_in_valid_o  = (r_state == ST_ISSUE) && !flush_i;
  assign fpu_out_ready_o = w_in_flight && !flush_i;
  assign fpu_rm_o        = r_rm;
  assign fpu_flush_o     = rst_ni && (flush_i || r_timeout);

  assign w_accept  = dec_valid_i && dec_ready_o;
  assign w_capture = fpu_out_valid_i && fpu_out_ready_o;

  assign wb_valid_o   = (r_state == ST_WB) && !flush_i;
  assign fflags_we_o  = (r_state == ST_WB) && !flush_i;
  assign wb_fp_o      = r_fp_wb;
  assign wb_rd_o      = r_rd;
  assign wb_data_o    = r_data;
  assign fflags_o     = r_status;
  assign illegal_rm_o = r_illegal;
  assign timeout_o    = r_timeout;
  assign busy_o       = (r_state != ST_IDLE);
  assign dbg_state_o  = r_state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_fp_wb   <= 1'b0;
      r_rm      <= '0;
      r_data    <= '0;
      r_status  <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      if (flush_i) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              if (w_rm_legal) begin
                r_rd    <= dec_rd_i;
                r_fp_wb <= dec_fp_wb_i;
                r_rm    <= w_rm;
                r_cnt   <= '0;
                r_state <= ST_ISSUE;
              end else begin
                // Instruction is consumed but never reaches the FPU.
                r_illegal <= 1'b1;
              end
            end
          end
          ST_ISSUE, ST_WAIT: begin
            // A result on the issue-handshake cycle skips WAIT entirely.
            if (w_capture) begin
              r_data   <= fpu_result_i;
              r_status <= fpu_status_i;
              r_state  <= ST_WB;
            end else if (r_cnt == CNT_LAST) begin
              r_cnt     <= CNT_MAX;
              r_timeout <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              if ((r_state == ST_ISSUE) && fpu_in_ready_i) begin
                r_state <= ST_WAIT;
              end
            end
          end
          ST_WB: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_brq_fpu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_brq_fpu_ctrl
// Self-checking bench for brq_fpu_ctrl. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled on the falling edge. Expected
// writebacks are queued by the stimulus and popped by a separate monitor.
// ----------------------------------------------------------------------------
module tb_brq_fpu_ctrl;

  localparam int WIDTH   = 64;
  localparam int TIMEOUT = 64;
  localparam int EXP_W   = 1 + 5 + WIDTH + 5;

  logic             clk;
  logic             rst_ni;
  logic             dec_valid_i;
  logic             dec_ready_o;
  logic [2:0]       dec_rm_i;
  logic [4:0]       dec_rd_i;
  logic             dec_fp_wb_i;
  logic [2:0]       frm_csr_i;
  logic             fpu_in_valid_o;
  logic             fpu_in_ready_i;
  logic [2:0]       fpu_rm_o;
  logic             fpu_out_valid_i;
  logic             fpu_out_ready_o;
  logic [WIDTH-1:0] fpu_result_i;
  logic [4:0]       fpu_status_i;
  logic             fpu_flush_o;
  logic             flush_i;
  logic             wb_valid_o;
  logic             wb_fp_o;
  logic [4:0]       wb_rd_o;
  logic [WIDTH-1:0] wb_data_o;
  logic             fflags_we_o;
  logic [4:0]       fflags_o;
  logic             illegal_rm_o;
  logic             timeout_o;
  logic             busy_o;
  logic [1:0]       dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_exp;

  brq_fpu_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .dec_valid_i     (dec_valid_i),
    .dec_ready_o     (dec_ready_o),
    .dec_rm_i        (dec_rm_i),
    .dec_rd_i        (dec_rd_i),
    .dec_fp_wb_i     (dec_fp_wb_i),
    .frm_csr_i       (frm_csr_i),
    .fpu_in_valid_o  (fpu_in_valid_o),
    .fpu_in_ready_i  (fpu_in_ready_i),
    .fpu_rm_o        (fpu_rm_o),
    .fpu_out_valid_i (fpu_out_valid_i),
    .fpu_out_ready_o (fpu_out_ready_o),
    .fpu_result_i    (fpu_result_i),
    .fpu_status_i    (fpu_status_i),
    .fpu_flush_o     (fpu_flush_o),
    .flush_i         (flush_i),
    .wb_valid_o      (wb_valid_o),
    .wb_fp_o         (wb_fp_o),
    .wb_rd_o         (wb_rd_o),
    .wb_data_o       (wb_data_o),
    .fflags_we_o     (fflags_we_o),
    .fflags_o        (fflags_o),
    .illegal_rm_o    (illegal_rm_o),
    .timeout_o       (timeout_o),
    .busy_o          (busy_o),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [2:0] model_rm(input logic [2:0] rm, input logic [2:0] frm);
    return (rm == 3'd7) ? frm : rm;
  endfunction

  function automatic bit model_legal(input logic [2:0] rm, input logic [2:0] frm);
    return (model_rm(rm, frm) < 3'd5);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_ni && (wb_valid_o || fflags_we_o)) begin
      check("fflags_we_with_wb", 128'(fflags_we_o), 128'(wb_valid_o));
      if (wb_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected: got wb_valid_o=1 rd=%0d expected no writeback", wb_rd_o);
        end else begin
          mon_exp = exp_q.pop_front();
          check("wb_payload", 128'({wb_fp_o, wb_rd_o, wb_data_o, fflags_o}), 128'(mon_exp));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL idle_wait: busy_o still 1 after 100 cycles, expected 0");
    end
  endtask

  // Presents one instruction; returns #1 after the accepting edge (cycle 1).
  task automatic issue_dec(input logic [2:0] rm, input logic [2:0] frm,
                           input logic [4:0] rd, input logic fp);
    @(posedge clk);
    #1;
    dec_valid_i = 1'b1;
    dec_rm_i    = rm;
    frm_csr_i   = frm;
    dec_rd_i    = rd;
    dec_fp_wb_i = fp;
    @(negedge clk);
    check("dec_ready_idle", 128'(dec_ready_o), 128'(1));
    @(posedge clk);
    #1;
    dec_valid_i = 1'b0;
    dec_rm_i    = 3'($urandom_range(0, 7));
  endtask

  task automatic run_op(input logic [2:0] rm, input logic [2:0] frm, input logic [4:0] rd,
                        input logic fp, input logic [WIDTH-1:0] data, input logic [4:0] status,
                        input int in_dly, input int out_dly);
    logic [2:0] erm;
    int in_cnt;
    erm = model_rm(rm, frm);
    issue_dec(rm, frm, rd, fp);
    if (!model_legal(rm, frm)) begin
      @(negedge clk);
      check("illegal_pulse", 128'(illegal_rm_o), 128'(1));
      check("illegal_no_issue", 128'(fpu_in_valid_o), 128'(0));
      check("illegal_not_busy", 128'(busy_o), 128'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("illegal_one_cycle", 128'(illegal_rm_o), 128'(0));
      return;
    end
    exp_q.push_back({fp, rd, data, status});
    in_cnt = 0;
    for (int k = 0; k <= in_dly + out_dly; k++) begin
      fpu_in_ready_i  = (k >= in_dly);
      fpu_out_valid_i = (k == in_dly + out_dly);
      fpu_result_i    = fpu_out_valid_i ? data : {$urandom, $urandom};
      fpu_status_i    = fpu_out_valid_i ? status : 5'($urandom);
      @(negedge clk);
      if (fpu_in_valid_o) begin
        in_cnt++;
        check("fpu_rm", 128'(fpu_rm_o), 128'(erm));
      end
      check("fpu_out_ready", 128'(fpu_out_ready_o), 128'(1));
      @(posedge clk);
      #1;
    end
    fpu_in_ready_i  = 1'b0;
    fpu_out_valid_i = 1'b0;
    check("issue_hold_cycles", 128'(in_cnt), 128'(in_dly + 1));
    @(negedge clk);
    check("wb_latency", 128'(wb_valid_o), 128'(1));
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_ni          = 1'b0;
    dec_valid_i     = 1'b0;
    dec_rm_i        = '0;
    dec_rd_i        = '0;
    dec_fp_wb_i     = 1'b0;
    frm_csr_i       = '0;
    fpu_in_ready_i  = 1'b0;
    fpu_out_valid_i = 1'b0;
    fpu_result_i    = '0;
    fpu_status_i    = '0;
    flush_i         = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          128'({dec_ready_o, fpu_in_valid_o, fpu_rm_o, fpu_out_ready_o, fpu_flush_o,
                wb_valid_o, wb_fp_o, wb_rd_o, fflags_we_o, fflags_o, illegal_rm_o,
                timeout_o, busy_o}), 128'(0));
    check("reset_wb_data", 128'(wb_data_o), 128'(0));
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 128'(dec_ready_o), 128'(1));

    // Combinational FPU: writeback two cycles after acceptance.
    run_op(3'd0, 3'd0, 5'd1, 1'b1, 64'h3FF0_0000_0000_0000, 5'h01, 0, 0);
    // DYN rounding: legal and illegal frm.
    run_op(3'd7, 3'd3, 5'd2, 1'b0, 64'h1234_5678_9ABC_DEF0, 5'h10, 0, 1);
    run_op(3'd7, 3'd5, 5'd3, 1'b1, 64'h0, 5'h00, 0, 0);
    run_op(3'd6, 3'd0, 5'd4, 1'b1, 64'h0, 5'h00, 0, 0);
    // Slow FPU: ready low 3 cycles, result 4 cycles after issue.
    run_op(3'd4, 3'd0, 5'd31, 1'b0, 64'hDEAD_BEEF_0000_0001, 5'h1F, 3, 4);

    // Flush in WAIT: no writeback for the abandoned operation.
    issue_dec(3'd1, 3'd0, 5'd5, 1'b1);
    fpu_in_ready_i = 1'b1;
    @(posedge clk);
    #1;
    fpu_in_ready_i = 1'b0;
    @(negedge clk);
    check("wait_busy", 128'(busy_o), 128'(1));
    check("wait_no_issue", 128'(fpu_in_valid_o), 128'(0));
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_passthru", 128'(fpu_flush_o), 128'(1));
    check("flush_no_ready", 128'(dec_ready_o), 128'(0));
    @(posedge clk);
    #1;
    flush_i         = 1'b0;
    fpu_out_valid_i = 1'b1;
    fpu_result_i    = 64'hBAD0_BAD0_BAD0_BAD0;
    fpu_status_i    = 5'h1F;
    @(negedge clk);
    check("flush_idle", 128'(busy_o), 128'(0));
    check("flush_released", 128'(fpu_flush_o), 128'(0));
    @(posedge clk);
    #1;
    fpu_out_valid_i = 1'b0;
    @(negedge clk);
    check("flush_no_wb", 128'({wb_valid_o, fflags_we_o}), 128'(0));

    // Flush coinciding with a decoder request: not accepted.
    @(posedge clk);
    #1;
    flush_i     = 1'b1;
    dec_valid_i = 1'b1;
    dec_rm_i    = 3'd0;
    @(negedge clk);
    check("flush_blocks_accept", 128'(dec_ready_o), 128'(0));
    @(posedge clk);
    #1;
    flush_i     = 1'b0;
    dec_valid_i = 1'b0;
    @(negedge clk);
    check("flush_accept_idle", 128'(busy_o), 128'(0));

    // Timeout: issue accepted, result never arrives.
    begin
      int cyc;
      bit found;
      issue_dec(3'd2, 3'd0, 5'd6, 1'b0);
      fpu_in_ready_i = 1'b1;
      cyc   = 1;
      found = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (timeout_o) begin
          found = 1;
          break;
        end
        @(posedge clk);
        #1;
        fpu_in_ready_i = 1'b0;
        cyc++;
      end
      check("timeout_seen", 128'(found), 128'(1));
      check("timeout_cycle", 128'(cyc), 128'(TIMEOUT + 1));
      check("timeout_flush", 128'(fpu_flush_o), 128'(1));
      check("timeout_idle", 128'({busy_o, dec_ready_o}), 128'(2'b01));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("timeout_one_cycle", 128'({timeout_o, fpu_flush_o}), 128'(0));
    end

    // Reset in WAIT: abandoned, nothing after release.
    issue_dec(3'd3, 3'd0, 5'd7, 1'b1);
    fpu_in_ready_i = 1'b1;
    @(posedge clk);
    #1;
    fpu_in_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    #1;
    check("reset_busy_drop", 128'({busy_o, dec_ready_o, fpu_out_ready_o}), 128'(0));
    @(posedge clk);
    #1;
    rst_ni          = 1'b1;
    fpu_out_valid_i = 1'b1;
    fpu_result_i    = 64'hFFFF_0000_FFFF_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_no_wb", 128'({wb_valid_o, fflags_we_o, busy_o}), 128'(0));
      @(posedge clk);
      #1;
    end
    fpu_out_valid_i = 1'b0;

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 5'($urandom),
             1'($urandom), {$urandom, $urandom}, 5'($urandom),
             $urandom_range(0, 4), $urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/brq_fpu_ctrl.md
BRQ_FPU_CTRL -- requirements
Module: brq_fpu_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64: FPU operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum cycles an operation may stay outstanding at the FPU.
REQ-003 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port dec_valid_i, input, 1: decoder presents an FP instruction.
REQ-006 SHALL have port dec_ready_o, output, 1: controller accepts the instruction.
REQ-007 SHALL have port dec_rm_i, input, 3: instruction rm field.
REQ-008 SHALL have port dec_rd_i, input, 5: destination register index.
REQ-009 SHALL have port dec_fp_wb_i, input, 1: 1 selects FP regfile, 0 selects integer regfile.
REQ-010 SHALL have port frm_csr_i, input, 3: CSR frm value.
REQ-011 SHALL have port fpu_in_valid_o / fpu_in_ready_i, output / input, 1 each: FPU issue handshake.
REQ-012 SHALL have port fpu_rm_o, output, 3: resolved rounding mode to the FPU.
REQ-013 SHALL have port fpu_out_valid_i / fpu_out_ready_o, input / output, 1 each: FPU result handshake.
REQ-014 SHALL have port fpu_result_i, input, WIDTH: FPU result.
REQ-015 SHALL have port fpu_status_i, input, 5: FPU exception flags {NV,DZ,OF,UF,NX}.
REQ-016 SHALL have port fpu_flush_o, output, 1: flush to the FPU.
REQ-017 SHALL have port flush_i, input, 1: pipeline flush.
REQ-018 SHALL have ports wb_valid_o, wb_fp_o, wb_rd_o (5), wb_data_o (WIDTH), all outputs: writeback.
REQ-019 SHALL have ports fflags_we_o, output, 1, and fflags_o, output, 5: fflags accrual to CSR.
REQ-020 SHALL have ports illegal_rm_o and timeout_o, outputs, 1 each: one-cycle error pulses.
REQ-021 SHALL have port busy_o, output, 1: operation in flight.

Function
REQ-022 SHALL implement states IDLE, ISSUE, WAIT, WB.
REQ-023 Rounding-mode resolution SHALL be: rm = (dec_rm_i == 3'b111) ? frm_csr_i : dec_rm_i; resolved values 5, 6 and 7 are illegal.
REQ-024 In IDLE, dec_ready_o SHALL be high (flush_i low); on dec_valid_i with a legal rm, the controller SHALL latch rd, fp_wb and rm, and go to ISSUE.
REQ-025 An illegal rm SHALL pulse illegal_rm_o for one cycle, consume the instruction, and stay in IDLE without issuing.
REQ-026 In ISSUE, fpu_in_valid_o SHALL be held high with a stable fpu_rm_o until fpu_in_ready_i; the controller SHALL then go to WAIT.
REQ-027 fpu_out_ready_o SHALL be high in ISSUE and WAIT.
REQ-028 Result capture (fpu_out_valid_i & fpu_out_ready_o) SHALL register the result and status and go to WB; a capture coinciding with the issue handshake SHALL go directly from ISSUE to WB.
REQ-029 In WB, the controller SHALL for exactly one cycle assert wb_valid_o with the registered wb_fp_o/wb_rd_o/wb_data_o, assert fflags_we_o with fflags_o = captured status, and then go to IDLE.
REQ-030 Minimum latency SHALL be acceptance at cycle 0 and wb_valid_o at cycle 2; there SHALL be no back-to-back acceptance (the next acceptance is no earlier than the cycle after WB).
REQ-031 A 0..TIMEOUT counter SHALL clear on entry to ISSUE and increment each cycle in ISSUE/WAIT; on reaching TIMEOUT, the controller SHALL pulse timeout_o and fpu_flush_o and go to IDLE without writeback.
REQ-032 flush_i SHALL drive fpu_flush_o combinationally and force IDLE next cycle from any state, suppressing wb_valid_o, fflags_we_o and acceptance in that cycle.
REQ-033 When flush_i and dec_valid_i coincide, flush SHALL win and the instruction SHALL not be accepted.
REQ-034 busy_o SHALL equal (state != IDLE).

Reset
REQ-035 Reset SHALL force state IDLE, counter 0, and all registered fields 0.
REQ-036 All outputs SHALL be 0 during reset, except dec_ready_o, which SHALL be 0 while rst_ni is low.
REQ-037 Reset asserted mid-operation SHALL abandon the operation with no writeback or fflags after release.

Structure
REQ-038 brq_pkg SHALL hold fpu_ctrl_state_e, the rounding-mode constants (RNE..RMM, DYN) and the fflags bit positions.
REQ-039 Rounding-mode resolution and legality SHALL be one combinational sub-module, brq_fpu_rm_resolve.

Verification
REQ-040 dec_rm_i=0, combinational FPU (in_ready=1, out_valid same cycle), result=64'h3FF0_0000_0000_0000, status=5'h01 -> wb_valid_o at cycle 2 with that data, fflags_o=5'h01.
REQ-041 dec_rm_i=7, frm_csr_i=3 -> fpu_rm_o=3; with frm_csr_i=5 -> illegal_rm_o pulse, no fpu_in_valid_o.
REQ-042 fpu_in_ready_i low for 3 cycles, out_valid 4 cycles later -> fpu_in_valid_o held with stable rm, exactly one wb_valid_o pulse.
REQ-043 flush_i asserted in WAIT -> fpu_flush_o same cycle, IDLE next cycle; a later out_valid produces no wb/fflags.
REQ-044 fpu_out_valid_i never asserted -> timeout_o pulse at TIMEOUT=64 cycles, then IDLE with dec_ready_o=1.
REQ-045 rst_ni dropped in WAIT -> busy_o=0 immediately, no writeback after release.
